// File: rtl/count_pkg.sv
// Shared definitions for the counter family: state encoding, default sizing
// and the load-value clamp used by both the up- and down-counters.
package count_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned DEF_MX    = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int unsigned clamp_mx(input int unsigned val, input int unsigned mx);
        return (val > mx) ? mx : val;
    endfunction

endpackage

// File: rtl/count_down_loop.sv
// Loadable down-counter with run/hold control; stops with a done pulse at zero
// or reloads MX and keeps running with a wrap pulse.
module count_down_loop
    import count_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned MX    = DEF_MX
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MX_W = WIDTH'(MX);

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;
    logic [WIDTH-1:0] w_load_clamped;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;
    logic             w_busy_d;
    logic             w_done_d;
    logic             w_wrap_d;

    assign w_load_clamped = WIDTH'(clamp_mx(32'(i_load_val), MX));

    // Priority within each state: load > pause > start > decrement.
    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_done_d  = 1'b0;
        w_wrap_d  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_count_d = w_load_clamped;
                end else if (i_start) begin
                    w_state_d = ST_RUN;
                    if (r_count == '0) w_count_d = MX_W;
                end
            end
            ST_RUN: begin
                if (i_load) begin
                    w_count_d = w_load_clamped;
                end else if (i_pause) begin
                    w_state_d = ST_HOLD;
                end else if (r_count == '0) begin
                    if (i_auto_reload) begin
                        w_count_d = MX_W;
                        w_wrap_d  = 1'b1;
                    end else begin
                        w_state_d = ST_DONE;
                        w_done_d  = 1'b1;
                    end
                end else begin
                    w_count_d = r_count - WIDTH'(1);
                end
            end
            ST_HOLD: begin
                if (i_load) begin
                    w_count_d = w_load_clamped;
                end else if (i_start) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign w_busy_d = (w_state_d == ST_RUN) || (w_state_d == ST_HOLD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_wrap  <= w_wrap_d;
        end
    end

    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_count_down_loop.sv
// Bench for count_down_loop: directed scenarios plus random stimulus, with an
// MX=5 and an MX=0 instance both checked against a behavioural model.
module tb_count_down_loop;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         pause;
    logic         load;
    logic         ar;
    logic [W-1:0] load_val;

    logic [W-1:0] count5;
    logic         busy5;
    logic         done5;
    logic         wrap5;
    logic [W-1:0] count0;
    logic         busy0;
    logic         done0;
    logic         wrap0;

    int vectors     = 0;
    int miscompares = 0;

    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_DONE} mstate_e;
    mstate_e ms[2];
    int      mc[2];
    bit      md[2];
    bit      mw[2];
    int      mmx[2] = '{5, 0};

    always #5 clk = ~clk;

    count_down_loop #(.WIDTH(W), .MX(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_pause      (pause),
        .i_load       (load),
        .i_load_val   (load_val),
        .i_auto_reload(ar),
        .o_count      (count5),
        .o_busy       (busy5),
        .o_done       (done5),
        .o_wrap       (wrap5)
    );

    count_down_loop #(.WIDTH(W), .MX(0)) dut0 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_pause      (pause),
        .i_load       (load),
        .i_load_val   (load_val),
        .i_auto_reload(ar),
        .o_count      (count0),
        .o_busy       (busy0),
        .o_done       (done0),
        .o_wrap       (wrap0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = M_IDLE;
            mc[k] = 0;
            md[k] = 0;
            mw[k] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_edge(input int k);
        int lv;
        lv    = (int'(load_val) > mmx[k]) ? mmx[k] : int'(load_val);
        md[k] = 0;
        mw[k] = 0;
        case (ms[k])
            M_IDLE: begin
                if (load) mc[k] = lv;
                else if (start) begin
                    if (mc[k] == 0) mc[k] = mmx[k];
                    ms[k] = M_RUN;
                end
            end
            M_RUN: begin
                if (load) mc[k] = lv;
                else if (pause) ms[k] = M_HOLD;
                else if (mc[k] == 0) begin
                    if (ar) begin
                        mc[k] = mmx[k];
                        mw[k] = 1;
                    end else begin
                        ms[k] = M_DONE;
                        md[k] = 1;
                    end
                end else mc[k] = mc[k] - 1;
            end
            M_HOLD: begin
                if (load) mc[k] = lv;
                else if (start) ms[k] = M_RUN;
            end
            default: ms[k] = M_IDLE;
        endcase
    endtask

    task automatic check_all(input string tag);
        bit eb;
        for (int k = 0; k < 2; k++) begin
            eb = (ms[k] == M_RUN) || (ms[k] == M_HOLD);
            if (k == 0) begin
                chk({tag, "_count5"}, 32'(count5), 32'(mc[k]));
                chk({tag, "_busy5"}, 32'(busy5), 32'(eb));
                chk({tag, "_done5"}, 32'(done5), 32'(md[k]));
                chk({tag, "_wrap5"}, 32'(wrap5), 32'(mw[k]));
            end else begin
                chk({tag, "_count0"}, 32'(count0), 32'(mc[k]));
                chk({tag, "_busy0"}, 32'(busy0), 32'(eb));
                chk({tag, "_done0"}, 32'(done0), 32'(md[k]));
                chk({tag, "_wrap0"}, 32'(wrap0), 32'(mw[k]));
            end
        end
    endtask

    // Called away from the rising edge; drives inputs, takes one edge, checks.
    task automatic step(input bit st, input bit ps, input bit ld, input int lv, input bit a,
                        input string tag);
        start    = st;
        pause    = ps;
        load     = ld;
        load_val = W'(lv);
        ar       = a;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_edge(k);
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && ms[0] != M_IDLE; i++) step(0, 0, 0, 0, 0, tag);
        chk({tag, "_idle"}, 32'(busy5), 32'(0));
    endtask

    initial begin
        int wraps;
        int dones;
        int n_edges;
        rst      = 1'b1;
        start    = 1'b0;
        pause    = 1'b0;
        load     = 1'b0;
        ar       = 1'b0;
        load_val = '0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // MX=0 instance: start, done next edge, idle after; MX=5 reaches 3.
        step(1, 0, 0, 0, 0, "mx0_start");
        chk("mx0_busy", 32'(busy0), 32'(1));
        step(0, 0, 0, 0, 0, "mx0_done");
        chk("mx0_donepulse", 32'(done0), 32'(1));
        chk("mx0_busyfall", 32'(busy0), 32'(0));
        step(0, 0, 0, 0, 0, "mx0_idle");
        chk("mx0_doneclr", 32'(done0), 32'(0));
        chk("midrst_pre", 32'(count5), 32'(3));
        async_reset("midrst");
        chk("midrst_count", 32'(count5), 32'(0));
        chk("midrst_busy", 32'(busy5), 32'(0));

        // Basic countdown 5..0, done, idle.
        step(1, 0, 0, 0, 0, "basic_start");
        chk("basic_c5", 32'(count5), 32'(5));
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 0, 0, "basic_dec");
            chk("basic_seq", 32'(count5), 32'(i));
        end
        step(0, 0, 0, 0, 0, "basic_term");
        chk("basic_done", 32'(done5), 32'(1));
        chk("basic_busyfall", 32'(busy5), 32'(0));
        step(0, 0, 0, 0, 0, "basic_idle");
        chk("basic_doneclr", 32'(done5), 32'(0));

        // Auto-reload for 14 edges.
        wraps = 0;
        dones = 0;
        step(1, 0, 0, 0, 1, "auto_start");
        for (int i = 0; i < 13; i++) begin
            step(0, 0, 0, 0, 1, "auto_run");
            if (wrap5) wraps++;
            if (done5) dones++;
        end
        chk("auto_wraps", 32'(wraps), 32'(2));
        chk("auto_dones", 32'(dones), 32'(0));
        chk("auto_last", 32'(count5), 32'(4));
        drain("auto_drain");

        // Pause at 3 for 4 cycles, resume; run length grows by 5 edges.
        step(1, 0, 0, 0, 0, "pr_start");
        n_edges = 1;
        step(0, 0, 0, 0, 0, "pr_dec");
        step(0, 0, 0, 0, 0, "pr_dec");
        n_edges += 2;
        chk("pr_at3", 32'(count5), 32'(3));
        repeat (4) begin
            step(0, 1, 0, 0, 0, "pr_hold");
            n_edges++;
        end
        chk("pr_held", 32'(count5), 32'(3));
        step(1, 0, 0, 0, 0, "pr_resume");
        n_edges++;
        chk("pr_resume_c", 32'(count5), 32'(3));
        step(0, 0, 0, 0, 0, "pr_next");
        n_edges++;
        chk("pr_c2", 32'(count5), 32'(2));
        for (int i = 0; i < 20 && !done5; i++) begin
            step(0, 0, 0, 0, 0, "pr_run");
            n_edges++;
        end
        chk("pr_length", 32'(n_edges), 32'(12));
        drain("pr_drain");

        // Load clamp, load-over-pause priority, load ignored in DONE.
        step(0, 0, 1, 7, 0, "ld_clamp");
        chk("ld_clamp_c", 32'(count5), 32'(5));
        step(1, 0, 0, 0, 0, "ld_start");
        step(0, 1, 1, 2, 0, "ld_prio");
        chk("ld_prio_c", 32'(count5), 32'(2));
        step(0, 0, 0, 0, 0, "ld_still_run");
        chk("ld_run_c", 32'(count5), 32'(1));
        step(0, 0, 0, 0, 0, "ld_z");
        step(0, 0, 0, 0, 0, "ld_term");
        step(0, 0, 1, 4, 0, "ld_in_done");
        chk("ld_done_ign", 32'(count5), 32'(0));
        step(1, 0, 0, 0, 0, "ld_restart");
        chk("ld_restart_c", 32'(count5), 32'(5));
        drain("ld_drain");

        // Random stimulus with occasional asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)),
                     $urandom_range(0, 1) == 1, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_down_loop.md
# count_down_loop

Loadable down-counter with a small run/hold control FSM. Counts from MX (or a loaded value) down to 0, then either stops with a one-cycle `done` pulse or reloads MX and continues with a `wrap` pulse. It pairs with the wrap-around up-counter used in lab timing blocks: it drains a count instead of building one, and supplies countdown and timeout ticks to control logic.

## Interface
- `WIDTH`, 3: counter width in bits.
- `MX`, 5: reload and terminal value. Must satisfy 0 ≤ MX ≤ 2^WIDTH−1.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset. Asynchronous and active-high.
- `start` input 1: begin counting from IDLE, or resume from HOLD.
- `pause` input 1: freeze the count while in RUN.
- `load` input 1: synchronous load of `load_val`.
- `load_val` input WIDTH: load value. Clamped to MX if greater.
- `auto_reload` input 1: 1 = reload MX at 0 and keep running; 0 = stop at 0.
- `count` output WIDTH: current count, registered.
- `busy` output 1: 1 in RUN and HOLD, registered.
- `done` output 1: one-cycle pulse on terminal stop, registered.
- `wrap` output 1: one-cycle pulse on auto-reload, registered.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset (async, any time, including mid-count): state=IDLE, count=0, busy=0, done=0, wrap=0.
- Input priority at each edge: rst > load > pause > start > decrement.
- load, in any state except DONE:
  - count ← min(load_val, MX).
  - State is unchanged.
  - No decrement that cycle.
  - load in DONE is ignored.
- IDLE:
  - start=1 → RUN.
  - If count==0 when start is sampled, count ← MX at the same edge. Otherwise count is kept.
  - pause is ignored.
- RUN, count>0 and no load/pause: count ← count−1.
- RUN, count==0:
  - auto_reload=1: count ← MX, wrap=1 for one cycle, stay in RUN.
  - auto_reload=0: → DONE, done=1 for one cycle, count stays 0.
- RUN, pause=1: → HOLD, count frozen, including at count==0.
- HOLD:
  - start=1 → RUN. Decrementing resumes on the following edge.
  - pause is ignored.
  - count is held.
- DONE: lasts exactly one cycle, then → IDLE unconditionally. start in DONE is ignored.
- Arithmetic is WIDTH-bit unsigned. The decrement never underflows, because the 0 case is handled explicitly.
- MX=0: RUN is entered with count=0, and the next edge produces done (or wrap with auto_reload).
- The counter is never in RUN with count>MX, because the clamp guarantees it.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- start→busy latency: 1 edge.
- With MX=5 and auto_reload=0, starting from count=0 with start at edge 0:
  - count=5 after edge 0.
  - count=4,3,2,1,0 after edges 1–5.
  - done=1 after edge 6.
  - IDLE and done=0 after edge 7.
  - Total: MX+1 decrementing edges plus the terminal edge.
- Auto-reload period is MX+1 cycles (5,4,3,2,1,0,5,…). `wrap` is high in the cycle where count shows MX again.
- `busy` falls at the same edge where `done` rises.
- `pause` and `start` are level-sampled. Holding either high has no effect beyond its first qualifying edge.

## Structure
- Shared package `count_pkg` holds:
  - The state enum: IDLE, RUN, HOLD, DONE, in a 2-bit encoding.
  - Default parameter constants (WIDTH=3, MX=5).
  - A `clamp_mx` function, so the up-counter and this block share width rules.
- Single module with a combined state/count register process and registered pulse outputs. No sub-module is needed.

## Test plan
- Reset mid-count: assert rst at count=3 in RUN → count=0, busy=0, IDLE immediately, with no clock edge needed.
- Basic countdown: MX=5, auto_reload=0, pulse start → count 5,4,3,2,1,0, then done=1 for exactly one cycle, then IDLE, busy=0.
- Auto-reload: auto_reload=1, run 14 cycles → count sequence 5..0,5..0,5,4. wrap pulses exactly twice, done never asserts.
- Pause/resume: pause at count=3 for 4 cycles → count holds 3. start → count 2 on the next edge, and the total run length extends by exactly 4+1 cycles.
- Load clamp and priority:
  - load_val=7 (MX=5) in IDLE → count=5.
  - load=1, pause=1, load_val=2 together in RUN → count=2, state stays RUN.
  - load in DONE → ignored.
- MX=0 instance: start → busy=1, done=1 on the next edge, IDLE on the edge after.
